// File: rtl/common_pkg.sv
// common_pkg: shared SID register-map constants and scheduler types.
package common_pkg;
  localparam int SID_ADDR_REG_WIDTH = 5;
  localparam int SID_NUM_REGS = 25;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with valid/ready push, pop strobe and head output.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic push, pop;
  assign empty_o = wr_q == rd_q;
  assign push_ready_o = (wr_q - rd_q) != (AW+1)'(DEPTH);
  assign head_o = mem_q[rd_q[AW-1:0]];
  assign push = push_valid_i & push_ready_o;
  assign pop = pop_i & ~empty_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push);
      rd_q <= rd_q + (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q[AW-1:0]] <= push_data_i;
endmodule

// File: rtl/sid_write_sched.sv
// sid_write_sched: arbitrates CPU writes, register-clear sequence and host FIFO onto the SID write port.
module sid_write_sched
  import common_pkg::*;
#(
  parameter int HOST_FIFO_DEPTH = 4
) (
  input  logic                          sys_clock_i,
  input  logic                          reset_i,
  input  logic                          clk1_en_i,
  input  logic                          cpu_wr_i,
  input  logic [SID_ADDR_REG_WIDTH-1:0] cpu_addr_i,
  input  logic [7:0]                    cpu_data_i,
  input  logic                          host_valid_i,
  output logic                          host_ready_o,
  input  logic [SID_ADDR_REG_WIDTH-1:0] host_addr_i,
  input  logic [7:0]                    host_data_i,
  input  logic                          clear_req_i,
  output logic                          sid_we_o,
  output logic [SID_ADDR_REG_WIDTH-1:0] sid_addr_o,
  output logic [7:0]                    sid_data_o,
  output logic                          clearing_o,
  output logic                          cpu_overrun_o
);
  localparam int AW = SID_ADDR_REG_WIDTH;
  clr_state_e state_q;
  logic [AW-1:0] idx_q, cpu_addr_q;
  logic [7:0] cpu_data_q;
  logic cpu_pend_q, overrun_q;
  logic [AW+7:0] head;
  logic fifo_empty, cpu_go, clr_go, host_go;
  sync_fifo #(.W(AW + 8), .DEPTH(HOST_FIFO_DEPTH)) u_host_fifo (
    .clk_i        (sys_clock_i),
    .rst_i        (reset_i),
    .push_valid_i (host_valid_i),
    .push_ready_o (host_ready_o),
    .push_data_i  ({host_addr_i, host_data_i}),
    .pop_i        (host_go),
    .head_o       (head),
    .empty_o      (fifo_empty)
  );
  // Fixed priority per slot: pending CPU, then clear, then host FIFO head.
  assign cpu_go = clk1_en_i & cpu_pend_q;
  assign clr_go = clk1_en_i & ~cpu_pend_q & (state_q == CLEAR);
  assign host_go = clk1_en_i & ~cpu_pend_q & (state_q != CLEAR) & ~fifo_empty;
  always_comb begin
    sid_we_o = cpu_go | clr_go | host_go;
    sid_addr_o = cpu_go ? cpu_addr_q : clr_go ? idx_q : host_go ? head[AW+7:8] : '0;
    sid_data_o = cpu_go ? cpu_data_q : host_go ? head[7:0] : '0;
  end
  assign clearing_o = state_q == CLEAR;
  assign cpu_overrun_o = overrun_q;
  always_ff @(posedge sys_clock_i) begin
    if (reset_i || clear_req_i) begin
      state_q <= CLEAR;
      idx_q <= '0;
    end else if (clr_go) begin
      state_q <= (idx_q == AW'(SID_NUM_REGS - 1)) ? IDLE : CLEAR;
      idx_q <= idx_q + 1'b1;
    end
  end
  always_ff @(posedge sys_clock_i) begin
    if (reset_i) begin
      cpu_pend_q <= 1'b0;
      overrun_q <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
    end else if (cpu_wr_i) begin
      cpu_pend_q <= 1'b1;
      overrun_q <= overrun_q | (cpu_pend_q & ~cpu_go);
      cpu_addr_q <= cpu_addr_i;
      cpu_data_q <= cpu_data_i;
    end else if (cpu_go) begin
      cpu_pend_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sid_write_sched.sv
// tb_sid_write_sched: randomized and directed stimulus against a queue-level reference model with a decoupled scoreboard.
module tb_sid_write_sched;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, en = 0, cwr = 0, hv = 0, clr = 0;
  logic [4:0] ca = 0, ha = 0;
  logic [7:0] cd = 0, hd = 0;
  logic hrdy, we, clearing, ovr_o;
  logic [4:0] wa;
  logic [7:0] wd;
  int checks = 0, errors = 0;
  logic [12:0] sb[$];
  bit m_pend, m_clr_on, m_ovr, exp_valid, exp_ready, exp_clr, exp_ovr, last_acc;
  logic [4:0] m_ca;
  logic [7:0] m_cd;
  logic [12:0] m_hq[$];
  int m_idx;

  sid_write_sched #(.HOST_FIFO_DEPTH(DEPTH)) dut (
    .sys_clock_i(clk), .reset_i(rst), .clk1_en_i(en), .cpu_wr_i(cwr), .cpu_addr_i(ca), .cpu_data_i(cd),
    .host_valid_i(hv), .host_ready_o(hrdy), .host_addr_i(ha), .host_data_i(hd), .clear_req_i(clr),
    .sid_we_o(we), .sid_addr_o(wa), .sid_data_o(wd), .clearing_o(clearing), .cpu_overrun_o(ovr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, record expectations, advance the model past the edge.
  task automatic cyc(bit e, bit w, logic [4:0] a, logic [7:0] d, bit v, logic [4:0] va, logic [7:0] vd, bit c, bit r);
    bit issued;
    @(negedge clk);
    en = r ? 1'b0 : e; cwr = w; ca = a; cd = d; hv = v; ha = va; hd = vd; clr = c; rst = r;
    exp_valid = !r;
    exp_ready = m_hq.size() < DEPTH;
    exp_clr = m_clr_on;
    exp_ovr = m_ovr;
    last_acc = 0;
    if (r) begin
      m_pend = 0; m_hq.delete(); m_clr_on = 1; m_idx = 0; m_ovr = 0;
      return;
    end
    issued = 0;
    if (e) begin
      if (m_pend) begin
        sb.push_back({m_ca, m_cd}); issued = 1;
      end else if (m_clr_on) begin
        sb.push_back({5'(m_idx), 8'h00});
        m_idx++;
        if (m_idx == 25) m_clr_on = 0;
      end else if (m_hq.size() > 0) begin
        sb.push_back(m_hq.pop_front());
      end
    end
    if (c) begin m_clr_on = 1; m_idx = 0; end
    if (w) begin
      if (m_pend && !issued) m_ovr = 1;
      m_pend = 1; m_ca = a; m_cd = d;
    end else if (issued) m_pend = 0;
    if (v && exp_ready) begin m_hq.push_back({va, vd}); last_acc = 1; end
  endtask

  task automatic idle(bit e);
    cyc(e, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_valid) begin
        chk("host_ready", 13'(hrdy), 13'(exp_ready));
        chk("clearing", 13'(clearing), 13'(exp_clr));
        chk("overrun", 13'(ovr_o), 13'(exp_ovr));
        if (we) begin
          if (sb.size() == 0) chk("unexpected_write", {wa, wd}, 13'h1fff);
          else chk("write", {wa, wd}, sb.pop_front());
        end else begin
          chk("idle_port", {wa, wd}, 13'h0);
          if (sb.size() > 0) chk("missing_write", 13'h1fff, sb.pop_front());
        end
      end
    end
  end

  initial begin
    int j;
    exp_valid = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 25 * 64 + 80; k++) idle(k % 64 == 63);
    // overrun: two strobes between slots
    cyc(0, 1, 5'd1, 8'hAA, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd2, 8'hBB, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) idle(k == 5);
    // CPU during clear, then clear restart at index 10
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 40; k++) idle(k % 4 == 3);
    cyc(1, 1, 5'd24, 8'h0F, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400 && m_idx != 10; k++) idle(k % 4 == 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 200; k++) idle(k % 4 == 3);
    // host fill: five entries against depth four, each held until accepted
    j = 0;
    for (int k = 0; k < 200 && j < 5; k++) begin
      cyc(k % 8 == 7, 0, 0, 0, 1, 5'(j + 3), 8'(8'h10 + j), 0, 0);
      if (last_acc) j++;
    end
    for (int k = 0; k < 40; k++) idle(k % 4 == 3);
    // reset with CPU pending and three host entries queued
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 5'(k), 8'hC0, 0, 0);
    cyc(0, 1, 5'd7, 8'h77, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 120; k++) idle(k % 4 == 3);
    // randomized traffic
    for (int k = 0; k < 6000; k++)
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, 5'($urandom_range(0, 24)), 8'($urandom),
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 24)), 8'($urandom),
          $urandom_range(0, 299) == 0, $urandom_range(0, 799) == 0);
    for (int k = 0; k < 400; k++) idle(k % 2 == 1);
    idle(0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", 13'(sb.size()), 13'h0);
    chk("model_idle", 13'({m_pend, m_clr_on, 3'(m_hq.size())}), 13'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sid_write_sched.md
# sid_write_sched

Write-port scheduler for the SID core inside the audio block. It shares the SID's single write port between CPU bus writes and a buffered host (MCU) register-write stream. It also sequences a full register clear after reset or on request, because the SID's own reset does not silence output. Every write it issues lands in a 1 MHz `clk1_en_i` slot.

## Interface
Parameters:
- `HOST_FIFO_DEPTH`, 4: host write queue depth; power of two, at least 2.

Ports:
- `sys_clock_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `clk1_en_i`  in  1  1 MHz clock enable; one cycle wide; defines the write slot.
- `cpu_wr_i`  in  1  CPU write strobe to the SID range; one cycle wide.
- `cpu_addr_i`  in  `SID_ADDR_REG_WIDTH`  CPU register address.
- `cpu_data_i`  in  8  CPU write data.
- `host_valid_i`  in  1  host write request.
- `host_ready_o`  out  1  host write accepted this cycle when both valid and ready are high.
- `host_addr_i`  in  `SID_ADDR_REG_WIDTH`  host register address.
- `host_data_i`  in  8  host write data.
- `clear_req_i`  in  1  pulse; starts or restarts the clear sequence.
- `sid_we_o`  out  1  SID write enable; to SID `iWE`.
- `sid_addr_o`  out  `SID_ADDR_REG_WIDTH`  to SID `iAddr`.
- `sid_data_o`  out  8  to SID `iDataW`.
- `clearing_o`  out  1  high while the clear sequence is active.
- `cpu_overrun_o`  out  1  sticky; a pending CPU write was overwritten before it issued.

## Operation
- **CPU holding register (one entry).**
  - `cpu_wr_i` captures the address and data and sets `cpu_pend`.
  - If `cpu_pend` is already set and not issuing this cycle, the new write overwrites it and sets `cpu_overrun_o`.
  - If the entry issues in the same cycle a new strobe arrives, the new write is captured with no overrun.
- **Host FIFO.**
  - Depth `HOST_FIFO_DEPTH`; `host_ready_o` = FIFO not full.
  - Order is preserved, and entries are never dropped except by reset.
- **Clear sequencer.** States: IDLE, CLEAR.
  - CLEAR writes 0x00 to registers 0 .. `SID_NUM_REGS`-1 (0..24) in ascending order, one per granted slot.
  - It returns to IDLE after register 24 is written.
  - `clear_req_i` in any state sets index to 0 and enters CLEAR.
- **Slot arbitration.** Evaluated only on cycles with `clk1_en_i`=1, fixed priority:
  1. Pending CPU write.
  2. CLEAR write.
  3. FIFO head.
- **Per slot.** At most one write issues; the losers wait.
- **CPU during CLEAR.** A CPU write during CLEAR issues first. If it targets a register not yet cleared, that register is later zeroed; this is accepted behaviour.
- **Write port output.**
  - `sid_we_o` = `clk1_en_i` AND (any source eligible).
  - `sid_addr_o`/`sid_data_o` = the winner's fields, else 0.
  - These outputs are combinational from registered state plus `clk1_en_i`.
- **Outputs after reset.**
  - State = CLEAR, index = 0, `clearing_o`=1.
  - `cpu_pend`=0, FIFO empty, `host_ready_o`=1, `cpu_overrun_o`=0.
  - `sid_we_o`=0 except in enable slots.

## Timing
- **CPU latency.** A CPU write captured at cycle t issues at the first `clk1_en_i` cycle at or after t+1. A strobe coincident with `clk1_en_i` issues at the next slot.
- **Host latency.** A host write accepted at cycle t is eligible from t+1, behind older entries and subject to CPU/CLEAR priority.
- **Clear duration.** A full clear with no CPU traffic takes exactly 25 slots.
- **`clearing_o` deassertion.** `clearing_o` falls in the cycle after the slot that writes register 24.
- **Dequeue timing.** The FIFO dequeues and the sequencer increments on the winning slot cycle. Both are registered and visible at t+1.
- **Simultaneous FIFO events.** Enqueue and dequeue in the same cycle while full: ready was low, so no enqueue occurs. At count 1, both may occur.
- **Reset mid-operation.** Reset drops pending CPU and host writes, then restarts the clear.

## Structure
- **`common_pkg`.** Add `SID_NUM_REGS` = 25 beside the existing `SID_ADDR_REG_WIDTH`.
- **Sub-module.** Use `sync_fifo` (parameterised width/depth, synchronous reset, valid/ready push, pop strobe, head output) for the host queue.
- **Instantiation.** Instantiate inside `audio` between the bus/MCU inputs and the SID.

## Test plan
- **Reset clear.** Release reset with `clk1_en_i` every 64 cycles and no traffic → exactly 25 writes, addresses 0..24, data 0x00; `clearing_o` low after the 25th.
- **CPU priority over clear.** During CLEAR, CPU writes 0x0F to address 24 → issued next slot; clear resumes; address 24 later zeroed; order verified.
- **Host FIFO fill.** Idle state, push 5 host writes back-to-back with depth 4 → `host_ready_o` low after 4 accepted; all 5 issue in order, one per slot.
- **CPU overrun.** Two CPU strobes (addr 1/0xAA, then addr 2/0xBB) between slots → only addr 2/0xBB issues; `cpu_overrun_o`=1 until reset.
- **Clear restart.** `clear_req_i` pulsed while index = 10 → next clear write is address 0; 25 further clear writes follow.
- **Reset mid-traffic.** Reset asserted with CPU pending and FIFO holding 3 entries → no stale writes; sequence restarts at address 0.
